// File: rtl/buzzer_scheduler_pkg.sv
// Shared definitions for the buzzer scheduler: FSM state encoding, grant
// codes reported on the grant output, and the beep pattern lengths in ticks.
package buzzer_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEY,
        ST_CHIME_ON,
        ST_CHIME_OFF,
        ST_ALARM_ON,
        ST_ALARM_OFF,
        ST_ALARM_GAP
    } state_t;

    localparam logic [1:0] GRANT_NONE  = 2'd0;
    localparam logic [1:0] GRANT_KEY   = 2'd1;
    localparam logic [1:0] GRANT_CHIME = 2'd2;
    localparam logic [1:0] GRANT_ALARM = 2'd3;

    // Pattern lengths, in 10 ms ticks (phase counter is 7 bits wide)
    localparam logic [6:0] KEY_TICKS        = 7'd3;
    localparam logic [6:0] BEEP_TICKS       = 7'd10;
    localparam logic [6:0] CHIME_LONG_TICKS = 7'd50;
    localparam logic [6:0] ALARM_GAP_TICKS  = 7'd80;
    localparam int         ALARM_BEEPS      = 4;

    // Both the chime and the alarm burst consist of four beeps (index 0..3)
    localparam logic [1:0] LAST_BEEP = 2'(ALARM_BEEPS - 1);

    function automatic logic is_alarm(input state_t s);
        return (s == ST_ALARM_ON) || (s == ST_ALARM_OFF) || (s == ST_ALARM_GAP);
    endfunction

    function automatic logic is_chime(input state_t s);
        return (s == ST_CHIME_ON) || (s == ST_CHIME_OFF);
    endfunction

endpackage

// File: rtl/buzzer_scheduler_tone_gen.sv
// Square-wave tone generator for the buzzer pin.
//   clk, rst  : clock, asynchronous active-low reset
//   en        : tone running (an ON state is held); low forces tone to 0
//   start     : synchronous restart: tone goes to 1 and the divider clears
//   sel_hi    : 1 selects HI_DIV, 0 selects LO_DIV half-period
//   tone      : registered square wave
module buzzer_scheduler_tone_gen #(
    parameter int LO_DIV = 25000,
    parameter int HI_DIV = 12500
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic start,
    input  logic sel_hi,
    output logic tone
);

    localparam int MAX_DIV = (LO_DIV > HI_DIV) ? LO_DIV : HI_DIV;
    localparam int CW      = $clog2(MAX_DIV + 1);
    localparam logic [CW-1:0] LO_LAST = CW'(LO_DIV - 1);
    localparam logic [CW-1:0] HI_LAST = CW'(HI_DIV - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] last;

    assign last = sel_hi ? HI_LAST : LO_LAST;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            tone <= 1'b0;
        end else if (start) begin
            cnt  <= '0;
            tone <= 1'b1;
        end else if (!en) begin
            cnt  <= '0;
            tone <= 1'b0;
        end else if (cnt == last) begin
            cnt  <= '0;
            tone <= ~tone;
        end else begin
            cnt  <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/buzzer_scheduler.sv
// Buzzer scheduler: arbitrates the single buzzer pin between alarm, hourly
// chime and key-click requesters (fixed priority alarm > chime > key) and
// plays each requester's beep pattern.
//   clk, rst    : clock, asynchronous active-low reset
//   alarm_req   : level, rising edge starts/restarts the alarm
//   alarm_stop  : pulse, silences an active alarm
//   chime_req   : level, rising edge latches a pending chime
//   key_req     : pulse, key click (only accepted when idle)
//   buzzer      : tone output
//   grant       : current owner (0 none, 1 key, 2 chime, 3 alarm)
//   busy        : grant != 0
//   chime_pend  : a chime is latched and waiting to play
module buzzer_scheduler
    import buzzer_scheduler_pkg::*;
#(
    parameter int TICK_DIV    = 500000,
    parameter int TONE_LO_DIV = 25000,
    parameter int TONE_HI_DIV = 12500,
    parameter int ALARM_TICKS = 6000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       alarm_req,
    input  logic       alarm_stop,
    input  logic       chime_req,
    input  logic       key_req,
    output logic       buzzer,
    output logic [1:0] grant,
    output logic       busy,
    output logic       chime_pend
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW = $clog2(ALARM_TICKS + 1);
    localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_TICKS - 1);

    state_t        state, next_state;
    logic [PW-1:0] presc;
    logic [6:0]    phase;
    logic [1:0]    beep_idx;
    logic [AW-1:0] alarm_cnt;
    logic          alarm_q, chime_q;

    logic alarm_rise, chime_rise, tick, last_beep, alarm_timeout;
    logic restart, enter, on_next, sel_hi;

    assign alarm_rise    = alarm_req & ~alarm_q;
    assign chime_rise    = chime_req & ~chime_q;
    assign tick          = (presc == TICK_LAST);
    assign last_beep     = (beep_idx == LAST_BEEP);
    assign alarm_timeout = is_alarm(state) && tick && (alarm_cnt == ALARM_LAST);

    // restart forces an entry even when the state does not change, so an
    // alarm re-trigger during an alarm restarts its pattern and timeout.
    assign enter   = restart || (next_state != state);
    assign on_next = (next_state == ST_KEY) || (next_state == ST_CHIME_ON) ||
                     (next_state == ST_ALARM_ON);
    // Only chime beeps 0..2 use the low tone
    assign sel_hi  = !((state == ST_CHIME_ON) && !last_beep);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        restart    = 1'b0;
        if (alarm_rise) begin
            next_state = ST_ALARM_ON;
            restart    = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (chime_pend)   next_state = ST_CHIME_ON;
                    else if (key_req) next_state = ST_KEY;
                end
                ST_KEY: begin
                    if (tick && phase == KEY_TICKS - 7'd1) next_state = ST_IDLE;
                end
                ST_CHIME_ON: begin
                    if (last_beep) begin
                        if (tick && phase == CHIME_LONG_TICKS - 7'd1) next_state = ST_IDLE;
                    end else if (tick && phase == BEEP_TICKS - 7'd1) begin
                        next_state = ST_CHIME_OFF;
                    end
                end
                ST_CHIME_OFF: begin
                    if (tick && phase == BEEP_TICKS - 7'd1) next_state = ST_CHIME_ON;
                end
                ST_ALARM_ON: begin
                    if (alarm_stop || alarm_timeout)             next_state = ST_IDLE;
                    else if (tick && phase == BEEP_TICKS - 7'd1) next_state = ST_ALARM_OFF;
                end
                ST_ALARM_OFF: begin
                    if (alarm_stop || alarm_timeout)             next_state = ST_IDLE;
                    else if (tick && phase == BEEP_TICKS - 7'd1)
                        next_state = last_beep ? ST_ALARM_GAP : ST_ALARM_ON;
                end
                ST_ALARM_GAP: begin
                    if (alarm_stop || alarm_timeout)                  next_state = ST_IDLE;
                    else if (tick && phase == ALARM_GAP_TICKS - 7'd1) next_state = ST_ALARM_ON;
                end
                default: next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alarm_q <= 1'b0;
            chime_q <= 1'b0;
        end else begin
            alarm_q <= alarm_req;
            chime_q <= chime_req;
        end
    end

    // Tick prescaler and phase counter restart on every state entry, so a
    // phase of N ticks lasts exactly N*TICK_DIV cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
            phase <= '0;
        end else if (enter || state == ST_IDLE) begin
            presc <= '0;
            phase <= '0;
        end else if (tick) begin
            presc <= '0;
            phase <= phase + 7'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Beep index advances when leaving an OFF state; from beep 3 it wraps
    // to 0, which is exactly what the alarm gap needs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beep_idx <= '0;
        end else if (restart || state == ST_IDLE) begin
            beep_idx <= '0;
        end else if (enter && (state == ST_CHIME_OFF || state == ST_ALARM_OFF)) begin
            beep_idx <= beep_idx + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alarm_cnt <= '0;
        end else if (restart || !is_alarm(state)) begin
            alarm_cnt <= '0;
        end else if (tick) begin
            alarm_cnt <= alarm_cnt + AW'(1);
        end
    end

    // Clearing on chime entry wins over a coincident (merged) edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chime_pend <= 1'b0;
        end else if (enter && next_state == ST_CHIME_ON) begin
            chime_pend <= 1'b0;
        end else if (chime_rise && !is_chime(state)) begin
            chime_pend <= 1'b1;
        end
    end

    always_comb begin
        case (state)
            ST_KEY:                                 grant = GRANT_KEY;
            ST_CHIME_ON, ST_CHIME_OFF:              grant = GRANT_CHIME;
            ST_ALARM_ON, ST_ALARM_OFF, ST_ALARM_GAP: grant = GRANT_ALARM;
            default:                                grant = GRANT_NONE;
        endcase
    end

    assign busy = (grant != GRANT_NONE);

    buzzer_scheduler_tone_gen #(
        .LO_DIV (TONE_LO_DIV),
        .HI_DIV (TONE_HI_DIV)
    ) u_tone (
        .clk    (clk),
        .rst    (rst),
        .en     (on_next),
        .start  (enter && on_next),
        .sel_hi (sel_hi),
        .tone   (buzzer)
    );

endmodule

// File: tb/tb_buzzer_scheduler.sv
module tb_buzzer_scheduler;

    localparam int TD = 4;
    localparam int LO = 2;
    localparam int HI = 1;
    localparam int AT = 200;

    localparam int BEEP_CYC     = 10 * TD;
    localparam int KEY_LEN      = 3 * TD;
    localparam int CHIME_SHORT  = 3 * 2 * BEEP_CYC;
    localparam int CHIME_LEN    = CHIME_SHORT + 50 * TD;
    localparam int ALARM_BURST  = 4 * 2 * BEEP_CYC;
    localparam int ALARM_PERIOD = ALARM_BURST + 80 * TD;
    localparam int ALARM_LEN    = AT * TD;

    logic       clk = 1'b0;
    logic       rst;
    logic       al, st, ch, ky;
    logic       buzzer;
    logic [1:0] grant;
    logic       busy;
    logic       chime_pend;

    int checks   = 0;
    int failures = 0;

    // Reference model: owner plus cycles elapsed since the owner started
    int m_owner;
    int m_t;
    int m_pend;
    logic m_aq, m_cq;

    buzzer_scheduler #(
        .TICK_DIV    (TD),
        .TONE_LO_DIV (LO),
        .TONE_HI_DIV (HI),
        .ALARM_TICKS (AT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .alarm_req  (al),
        .alarm_stop (st),
        .chime_req  (ch),
        .key_req    (ky),
        .buzzer     (buzzer),
        .grant      (grant),
        .busy       (busy),
        .chime_pend (chime_pend)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s at %0t: observed %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    function automatic int half(input int x, input int d);
        return (((x / d) % 2) == 0) ? 1 : 0;
    endfunction

    function automatic int exp_buzz();
        int w;
        case (m_owner)
            1: return half(m_t, HI);
            2: begin
                if (m_t < CHIME_SHORT) begin
                    w = m_t % (2 * BEEP_CYC);
                    return (w < BEEP_CYC) ? half(w, LO) : 0;
                end
                return half(m_t - CHIME_SHORT, HI);
            end
            3: begin
                w = m_t % ALARM_PERIOD;
                if (w < ALARM_BURST) begin
                    w = w % (2 * BEEP_CYC);
                    return (w < BEEP_CYC) ? half(w, HI) : 0;
                end
                return 0;
            end
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_owner = 0;
        m_t     = 0;
        m_pend  = 0;
        m_aq    = 1'b0;
        m_cq    = 1'b0;
    endtask

    task automatic model_step();
        logic arise, crise, chime_start;
        int   prev;
        arise       = al & ~m_aq;
        crise       = ch & ~m_cq;
        prev        = m_owner;
        chime_start = 1'b0;
        if (arise) begin
            m_owner = 3;
            m_t     = 0;
        end else begin
            case (m_owner)
                0: begin
                    if (m_pend != 0) begin
                        m_owner = 2; m_t = 0; chime_start = 1'b1;
                    end else if (ky) begin
                        m_owner = 1; m_t = 0;
                    end
                end
                1: begin m_t++; if (m_t == KEY_LEN) m_owner = 0; end
                2: begin m_t++; if (m_t == CHIME_LEN) m_owner = 0; end
                default: begin m_t++; if (st || m_t == ALARM_LEN) m_owner = 0; end
            endcase
        end
        if (chime_start)              m_pend = 0;
        else if (crise && prev != 2)  m_pend = 1;
        m_aq = al;
        m_cq = ch;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            #1;
            chk("grant",  32'(grant),      32'(m_owner));
            chk("busy",   32'(busy),       32'(m_owner != 0));
            chk("buzzer", 32'(buzzer),     32'(exp_buzz()));
            chk("pend",   32'(chime_pend), 32'(m_pend));
            ky = 1'b0;
            st = 1'b0;
        end
    endtask

    task automatic run_count(input int n, input logic [1:0] g, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            run(1);
            if (grant == g) cnt++;
        end
    endtask

    initial begin
        int cnt;
        rst = 1'b0;
        al = 1'b0; st = 1'b0; ch = 1'b0; ky = 1'b0;
        model_reset();
        #1;
        chk("rst_grant",  32'(grant),      32'd0);
        chk("rst_busy",   32'(busy),       32'd0);
        chk("rst_buzzer", 32'(buzzer),     32'd0);
        chk("rst_pend",   32'(chime_pend), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        run(3);

        // Key click
        ky = 1'b1;
        run_count(20, 2'd1, cnt);
        chk("key_len", 32'(cnt), 32'(KEY_LEN));

        // Full chime
        ch = 1'b1;
        run_count(460, 2'd2, cnt);
        chk("chime_len", 32'(cnt), 32'(CHIME_LEN));
        ch = 1'b0;
        run(2);

        // Alarm aborts chime during its second beep
        ch = 1'b1;
        run(95);
        al = 1'b1;
        run(1);
        chk("abort_grant", 32'(grant), 32'd3);
        run(20);
        st = 1'b1;
        run(1);
        run_count(500, 2'd2, cnt);
        chk("abort_no_replay", 32'(cnt), 32'd0);
        chk("abort_pend", 32'(chime_pend), 32'd0);
        al = 1'b0; ch = 1'b0;
        run(2);

        // Alarm held, no stop: timeout, no retrigger
        al = 1'b1;
        run_count(900, 2'd3, cnt);
        chk("alarm_timeout_len", 32'(cnt), 32'(ALARM_LEN));
        al = 1'b0;
        run(2);

        // Simultaneous alarm and chime edges, stop at cycle 100
        al = 1'b1; ch = 1'b1;
        run(1);
        chk("simul_pend", 32'(chime_pend), 32'd1);
        run(98);
        st = 1'b1;
        run(1);
        chk("simul_stop", 32'(grant), 32'd0);
        run_count(460, 2'd2, cnt);
        chk("simul_chime_len", 32'(cnt), 32'(CHIME_LEN));
        al = 1'b0; ch = 1'b0;
        run(2);

        // Async reset in the middle of ALARM_ON, release with alarm_req high
        al = 1'b1;
        run(10);
        #2 rst = 1'b0;
        #1;
        chk("async_grant",  32'(grant),  32'd0);
        chk("async_buzzer", 32'(buzzer), 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        run(1);
        chk("restart_grant",  32'(grant),  32'd3);
        chk("restart_buzzer", 32'(buzzer), 32'd1);
        run(5);
        al = 1'b0;
        run(2);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) al = ~al;
            if ($urandom_range(0, 149) == 0) ch = ~ch;
            st = ($urandom_range(0, 399) == 0);
            ky = ($urandom_range(0, 24) == 0);
            run(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
